// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from the pipeline, issues a single
// request/ack access to data memory, and returns extended load data or a
// fault. The pipeline is held (req_ready low) until the one-cycle response.
module lsu #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_nxt;
   logic [15:0] wait_cnt;
   logic        op_we;
   logic [2:0]  op_f3;
   logic [1:0]  op_off;

   logic        accept, bad_f3, misal, fault_req, timeout;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, ext_data;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   // Last waiting cycle: the counter started at 0 in the first ACCESS cycle.
   assign timeout   = (wait_cnt == 16'(MEM_TIMEOUT - 1));

   // Request decode: legal funct3, natural alignment, lane steering.
   always_comb begin
      bad_f3    = 1'b0;
      misal     = 1'b0;
      be_nxt    = 4'b1111;
      wdata_nxt = 32'h0;
      if (req_we)
         bad_f3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      else
         bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      case (req_funct3[1:0])
         2'b01:   misal = req_addr[0];
         2'b10:   misal = (req_addr[1:0] != 2'b00);
         default: misal = 1'b0;
      endcase
      if (req_we) begin
         case (req_funct3[1:0])
            2'b00: begin
               be_nxt    = 4'b0001 << req_addr[1:0];
               wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               be_nxt    = 4'b0011 << req_addr[1:0];
               wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: begin
               be_nxt    = 4'b1111;
               wdata_nxt = req_wdata;
            end
         endcase
      end
      fault_req = bad_f3 || misal;
   end

   // Load extraction from the returned word using the latched offset/size.
   always_comb begin
      sel_b    = mem_rdata[8*op_off +: 8];
      sel_h    = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_f3)
         3'b000:  ext_data = {{24{sel_b[7]}}, sel_b};
         3'b100:  ext_data = {24'h0, sel_b};
         3'b001:  ext_data = {{16{sel_h[15]}}, sel_h};
         3'b101:  ext_data = {16'h0, sel_h};
         default: ext_data = mem_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: faults skip the memory access entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fault_req ? RESP : ACCESS;
         ACCESS:  if (mem_ack || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered memory-side and response-side outputs plus wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         op_we     <= 1'b0;
         op_f3     <= 3'b0;
         op_off    <= 2'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (accept) begin
                  op_we  <= req_we;
                  op_f3  <= req_funct3;
                  op_off <= req_addr[1:0];
                  if (fault_req) begin
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= wdata_nxt;
                     mem_be    <= be_nxt;
                  end
               end
            end
            ACCESS: begin
               if (mem_ack || timeout) begin
                  rsp_valid <= 1'b1;
                  rsp_fault <= !mem_ack;
                  rsp_rdata <= (mem_ack && !op_we) ? ext_data : 32'h0;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_be    <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: word/sub-word access, faults, wait states,
// timeout and reset during an access.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   lsu #(.MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Issue one op, ack it ack_wait cycles into ACCESS (-1 = never), and
   // report latency, response, cycle-1 memory outputs and req_ready after.
   task automatic run_op(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_wait,
                         output int lat, output logic [31:0] rd,
                         output logic flt, output logic [3:0] be,
                         output logic [31:0] wd, output logic [31:0] ma,
                         output int req_cycles, output logic rdy);
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1; rd = 32'hFFFF_FFFF; flt = 1'b0; req_cycles = 0;
      be = mem_be; wd = mem_wdata; ma = mem_addr;
      for (int c = 1; c <= 40; c++) begin
         if (rsp_valid) begin
            lat = c; rd = rsp_rdata; flt = rsp_fault;
            break;
         end
         if (mem_req) req_cycles++;
         mem_ack = (ack_wait >= 0) && (c == 1 + ack_wait);
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      @(posedge clk); #1;
      rdy = req_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_fault, mem_req, mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 10000",
                  {req_ready, rsp_valid, rsp_fault, mem_req, mem_we});
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
         errors++;
         $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b",
                  rsp_rdata, mem_addr, mem_wdata, mem_be);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      int lat, rc; logic [31:0] rd, wd, ma; logic flt, rdy; logic [3:0] be;
      run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h1234_5678, 0,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if ({be, wd, ma} !== {4'b1111, 32'hDEADBEEF, 32'h100}) begin
         errors++;
         $display("FAIL sw_mem got be=%b wd=%h a=%h want 1111 deadbeef 100", be, wd, ma);
      end
      checks++;
      if (lat !== 2 || rd !== 32'h0 || flt !== 1'b0 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL sw_rsp got lat=%0d rd=%h f=%b rdy=%b want 2 0 0 1", lat, rd, flt, rdy);
      end
      run_op(1'b0, 3'b010, 32'h100, 32'h5555_5555, 32'hDEADBEEF, 0,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if ({be, wd} !== {4'b1111, 32'h0}) begin
         errors++;
         $display("FAIL lw_mem got be=%b wd=%h want 1111 0", be, wd);
      end
      checks++;
      if (lat !== 2 || rd !== 32'hDEADBEEF || flt !== 1'b0) begin
         errors++;
         $display("FAIL lw_rsp got lat=%0d rd=%h f=%b want 2 deadbeef 0", lat, rd, flt);
      end
   endtask

   task automatic test_subword_load();
      logic [2:0]  f3v [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] av  [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
      logic [31:0] ev  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h00007F81};
      int lat, rc; logic [31:0] rd, wd, ma; logic flt, rdy; logic [3:0] be;
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, f3v[i], av[i], 32'h0, 32'h80F0_7F81, 0,
                lat, rd, flt, be, wd, ma, rc, rdy);
         checks++;
         if (rd !== ev[i] || flt !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL subload_%0d got rd=%h f=%b lat=%0d want %h 0 2",
                     i, rd, flt, lat, ev[i]);
         end
      end
   endtask

   task automatic test_subword_store();
      int lat, rc; logic [31:0] rd, wd, ma; logic flt, rdy; logic [3:0] be;
      run_op(1'b1, 3'b000, 32'h301, 32'h0000_00AB, 32'h0, 0,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if ({be, wd, ma} !== {4'b0010, 32'hABABABAB, 32'h300}) begin
         errors++;
         $display("FAIL sb got be=%b wd=%h a=%h want 0010 abababab 300", be, wd, ma);
      end
      run_op(1'b1, 3'b001, 32'h302, 32'h5A5A_1234, 32'h0, 0,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if ({be, wd, ma} !== {4'b1100, 32'h12341234, 32'h300}) begin
         errors++;
         $display("FAIL sh got be=%b wd=%h a=%h want 1100 12341234 300", be, wd, ma);
      end
   endtask

   task automatic test_faults();
      logic        wev [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3v [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
      logic [31:0] av  [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
      int lat, rc; logic [31:0] rd, wd, ma; logic flt, rdy; logic [3:0] be;
      for (int i = 0; i < 4; i++) begin
         run_op(wev[i], f3v[i], av[i], 32'hCAFEF00D, 32'hFFFF_FFFF, 0,
                lat, rd, flt, be, wd, ma, rc, rdy);
         checks++;
         if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0 || rc !== 0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL fault_%0d got lat=%0d f=%b rd=%h reqs=%0d rdy=%b want 1 1 0 0 1",
                     i, lat, flt, rd, rc, rdy);
         end
      end
   endtask

   task automatic test_wait_timeout();
      int lat, rc; logic [31:0] rd, wd, ma; logic flt, rdy; logic [3:0] be;
      run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h0BAD_CAFE, 5,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if (lat !== 7 || rd !== 32'h0BADCAFE || flt !== 1'b0 || rc !== 6) begin
         errors++;
         $display("FAIL wait5 got lat=%0d rd=%h f=%b reqs=%0d want 7 0badcafe 0 6",
                  lat, rd, flt, rc);
      end
      run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_CAFE, -1,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if (lat !== 9 || rd !== 32'h0 || flt !== 1'b1 || rc !== 8 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL timeout got lat=%0d rd=%h f=%b reqs=%0d rdy=%b want 9 0 1 8 1",
                  lat, rd, flt, rc, rdy);
      end
   endtask

   task automatic test_reset_mid_access();
      int lat, rc; logic [31:0] rd, wd, ma; logic flt, rdy; logic [3:0] be;
      logic saw_rsp;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
      @(posedge clk); #1;              // cycle 1
      req_valid = 1'b0;
      @(posedge clk); #1;              // cycle 2
      rst = 1'b1;
      @(posedge clk); #1;              // cycle 3
      rst = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got req=%b rdy=%b vld=%b want 0 1 0",
                  mem_req, req_ready, rsp_valid);
      end
      saw_rsp = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (rsp_valid) saw_rsp = 1'b1;
      end
      checks++;
      if (saw_rsp !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_rsp got rsp_valid after reset want none");
      end
      run_op(1'b0, 3'b010, 32'h80, 32'h0, 32'h7654_3210, 1,
             lat, rd, flt, be, wd, ma, rc, rdy);
      checks++;
      if (lat !== 3 || rd !== 32'h76543210 || flt !== 1'b0) begin
         errors++;
         $display("FAIL rst_after_lw got lat=%0d rd=%h f=%b want 3 76543210 0", lat, rd, flt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_word();
      test_subword_load();
      test_subword_store();
      test_faults();
      test_wait_timeout();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute→memory path of the simple CPU. It consumes the ALU's `alu_result` as the effective address, together with rs2 store data and funct3. It drives a single-port data-memory request/acknowledge interface and returns aligned, sign- or zero-extended load data to writeback. It is multi-cycle: the pipeline holds the instruction until `rsp_valid`.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles to wait for `mem_ack` before aborting with a fault (1..65535).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  pipeline presents a memory operation
- `req_ready`  out  1  LSU can accept (high only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- `req_addr`  in  32  effective address (ALU result)
- `req_wdata`  in  32  store data (rs2)
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  extended load data; 0 for stores and faults
- `rsp_fault`  out  1  valid with `rsp_valid`: misaligned, unsupported funct3, or timeout
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  write enable
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `mem_wdata`  out  32  store data replicated into byte lanes
- `mem_be`  out  4  byte enables
- `mem_ack`  in  1  memory accepted/completed the access this cycle
- `mem_rdata`  in  32  read word, valid when `mem_ack` is high on a load

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ACCESS: `mem_req`=1.
  - RESP: `rsp_valid`=1.
- Accept on `req_valid && req_ready`. Latch `we`, `funct3`, `addr`, `wdata` and `addr[1:0]`, then decode:
  - Unsupported funct3 (load 011/110/111; store with funct3[2]=1 or 011) → fault.
  - Half with `addr[0]`=1 → fault.
  - Word with `addr[1:0]`≠0 → fault.
  - Otherwise → ACCESS.
- A faulting request goes directly to RESP with `rsp_fault`=1 and `rsp_rdata`=0. No memory access is issued.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are stable from registers for the whole state.
  - On `mem_ack`, go to RESP. For loads, capture the extracted data.
  - A wait counter counts cycles in ACCESS. If it reaches `MEM_TIMEOUT` without `mem_ack`, drop `mem_req` and go to RESP with `rsp_fault`=1.
- Byte enables by store size:
  - SB: `1<<addr[1:0]`, with `wdata[7:0]` replicated ×4.
  - SH: `4'b0011<<addr[1:0]`, with `wdata[15:0]` replicated ×2.
  - SW: `4'b1111`.
  - Loads drive `mem_be`=4'b1111 and `mem_wdata`=0.
- Load extraction:
  - Select byte `addr[1:0]` or halfword `addr[1]` from `mem_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP lasts exactly one cycle, then returns to IDLE. `rsp_*` outputs are registered and drop to 0 outside RESP.

## Timing
- Reset: state=IDLE, counter=0. Outputs: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- Cycle-level sequence with acceptance at cycle 0:
  - Cycle 1: `mem_req`=1.
  - If `mem_ack` arrives in cycle 1+k, `rsp_valid` is high in cycle 2+k.
  - `req_ready` returns in cycle 3+k.
  - Minimum latency accept→`rsp_valid` is 2 cycles; back-to-back throughput is one op per 3 cycles.
- Fault path: `rsp_valid` is high in cycle 1 and `req_ready` in cycle 2.
- Timeout: with no ack, `mem_req` is high for exactly `MEM_TIMEOUT` cycles (cycles 1..`MEM_TIMEOUT`). `rsp_valid`+`rsp_fault` are high in cycle `MEM_TIMEOUT`+1.
- Ignored inputs:
  - `req_*` are ignored outside IDLE; changing them mid-operation has no effect.
  - `mem_ack` outside ACCESS is ignored.
- `rst` in any state returns to IDLE on the next edge. An in-flight `mem_req` drops immediately and no `rsp_valid` is generated.

## Test plan
- Word store/load: SW addr 0x100, data 0xDEADBEEF, ack after 0 wait. Expect `mem_be`=1111 and `rsp_valid` 2 cycles after accept. Then LW 0x100 with `mem_rdata`=0xDEADBEEF → `rsp_rdata`=0xDEADBEEF, `rsp_fault`=0.
- Sub-word loads, `mem_rdata`=0x80F0_7F81:
  - LB 0x203 → 0xFFFFFF80
  - LBU 0x203 → 0x00000080
  - LH 0x202 → 0xFFFF80F0
  - LHU 0x200 → 0x00007F81
- Sub-word stores: SB 0x301 with data 0x000000AB → `mem_be`=0010, `mem_wdata`=0xABABABAB, `mem_addr`=0x300. SH 0x302 → `mem_be`=1100.
- Faults: LW 0x102, SH 0x101 and funct3=011 load. Each gives `rsp_valid` 1 cycle after accept with `rsp_fault`=1 and `rsp_rdata`=0, and `mem_req` never asserts.
- Wait states and timeout: ack after 5 cycles → `rsp_valid` at cycle 7. With `MEM_TIMEOUT`=8 and no ack → `mem_req` high for 8 cycles, then `rsp_fault`=1.
- Reset mid-ACCESS: assert `rst` 2 cycles after accept. Next cycle `mem_req`=0 and `req_ready`=1, no `rsp_valid`; a following LW completes normally.
